// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the 16x-oversampled receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// System-side byte handshake of the UART transmitter.
interface uart_tx_if;

  logic [7:0] TxD_par;
  logic       TxD_start;
  logic       TxD_ready;
  logic       TxD_busy;

  modport master (
    output TxD_par,
    output TxD_start,
    input  TxD_ready,
    input  TxD_busy
  );

  modport slave (
    input  TxD_par,
    input  TxD_start,
    output TxD_ready,
    output TxD_busy
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART serializer with a one-deep holding register, paced by Baud16Tick
// and gated by the far end's clear-to-send at every frame start.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  input  logic     Baud16Tick,
  input  logic     CTS_in,
  output logic     TxD_ser,
  uart_tx_if.slave sys
);

  localparam int              CntW     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(OVERSAMPLE - 1);
  localparam logic [2:0]      BitLast  = 3'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  uart_tx_state_t       state_q;
  logic [CntW-1:0]      tick_q;
  logic [CntW-1:0]      tick_d;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic                 ser_q;
  logic                 accept;
  logic                 launch;
  logic                 bit_end;

  assign accept  = sys.TxD_start && !hold_full_q;
  assign launch  = hold_full_q && CTS_in;
  assign bit_end = (tick_q == TickLast);
  assign tick_d  = bit_end ? '0 : tick_q + 1'b1;

  // Accept needs an empty holder and launch needs a full one, so the two
  // writes to hold_full_q below never collide.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ser_q       <= 1'b1;
    end else begin
      if (accept) begin
        hold_q      <= sys.TxD_par;
        hold_full_q <= 1'b1;
      end
      if (Baud16Tick) begin
        unique case (state_q)
          IDLE: begin
            tick_q <= '0;
            if (launch) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              ser_q       <= 1'b0;
              state_q     <= START;
            end
          end
          START: begin
            tick_q <= tick_d;
            if (bit_end) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              ser_q     <= shift_q[0];
            end
          end
          DATA: begin
            tick_q <= tick_d;
            if (bit_end) begin
              shift_q <= shift_q >> 1;
              if (bit_idx_q == BitLast) begin
                state_q    <= STOP;
                stop_idx_q <= 1'b0;
                ser_q      <= 1'b1;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
                ser_q     <= shift_q[1];
              end
            end
          end
          STOP: begin
            tick_q <= tick_d;
            if (bit_end) begin
              if (stop_idx_q == StopLast) begin
                if (launch) begin
                  shift_q     <= hold_q;
                  hold_full_q <= 1'b0;
                  ser_q       <= 1'b0;
                  state_q     <= START;
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                stop_idx_q <= stop_idx_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign TxD_ser       = ser_q;
  assign sys.TxD_ready = !hold_full_q;
  assign sys.TxD_busy  = (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
# uart_tx

Serializer for the USB-UART link: the transmit counterpart of the existing 16x-oversampled receiver. It accepts parallel bytes from the system side through a one-deep holding register and sends them on `TxD_ser` as 8N1 frames (optionally 8N2), LSB first. It runs on the same `sys_clk` / `Baud16Tick` pair as the receiver and honours the far end's clear-to-send before starting each frame.

## Interface
- `OVERSAMPLE`, 16: `Baud16Tick` pulses per bit period. The counter width is clog2(OVERSAMPLE).
- `STOP_BITS`, 1: number of stop bits, 1 or 2. Other values are illegal.
- `sys_clk` in 1: system clock. All logic is on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `Baud16Tick` in 1: single-cycle oversampling enable, OVERSAMPLE per bit.
- `TxD_par` in 8: byte to send. Sampled only on accept.
- `TxD_start` in 1: write strobe. A byte is accepted when `TxD_start && TxD_ready`.
- `TxD_ready` out 1: holding register empty, so a write may be accepted.
- `TxD_busy` out 1: a frame is on the line (state ≠ IDLE).
- `CTS_in` in 1: far end clear to send, active high. Assumed already synchronous to `sys_clk`.
- `TxD_ser` out 1: serial line, idle high. Driven directly from a flop.

## Operation
- Holding register: `hold_data[7:0]` and `hold_full`.
  - Accept sets `hold_full` and loads the data.
  - Transfer to the shifter clears `hold_full`.
  - `TxD_ready = ~hold_full`.
  - A write while full is ignored: no overwrite, no error.
  - Accept and transfer cannot coincide, because accept requires empty.
- States: IDLE, START, DATA, STOP. `bit_idx[2:0]` counts data bits. `stop_idx` counts stop bits. `tick_cnt` is the in-bit tick counter.
- IDLE:
  - `TxD_ser=1` and `tick_cnt=0`.
  - On a `Baud16Tick` cycle with `hold_full && CTS_in`: load the shifter from hold, clear `hold_full`, set `TxD_ser=0`, go to START.
- Every state other than IDLE, on each `Baud16Tick`: `tick_cnt` increments and wraps to 0 at OVERSAMPLE-1. The wrap cycle is `bit_end`. Between ticks nothing changes.
- START, on `bit_end`: go to DATA with `bit_idx=0` and `TxD_ser=shift[0]`.
- DATA, on `bit_end`:
  - Shift right.
  - If `bit_idx==7`: go to STOP with `TxD_ser=1`.
  - Otherwise increment `bit_idx` and drive the next bit.
- STOP, on `bit_end` of the last stop bit:
  - If `hold_full && CTS_in`: load the next byte and go directly to START with `TxD_ser=0`. There are no idle ticks between frames.
  - Otherwise go to IDLE.
- CTS behaviour:
  - `CTS_in` is sampled only at frame start: the IDLE launch or the STOP→START decision.
  - Deasserting it mid-frame never truncates the frame in progress.
- Reset, asserted at any time including mid-frame:
  - `TxD_ser=1` immediately (asynchronous), aborting the frame.
  - State returns to IDLE; `hold_full`, `tick_cnt`, `bit_idx` and `stop_idx` clear to 0.
  - The holding byte is discarded.
- Reset values of outputs: `TxD_ser=1`, `TxD_ready=1`, `TxD_busy=0`.

## Timing
- Start latency: the start bit begins (`TxD_ser` falls) at the first `Baud16Tick` edge strictly after the accepting edge, provided `CTS_in=1` on that tick. A tick coincident with the accept does not launch.
- Bit widths: every bit, including start and stop, lasts exactly OVERSAMPLE ticks.
- Frame length: OVERSAMPLE×(9+STOP_BITS) ticks, i.e. 160 for 8N1 and 176 for 8N2.
- `TxD_ready` timing:
  - Falls the cycle after accept.
  - Rises the cycle after the transfer into the shifter, i.e. at the start-bit edge.
  - The next byte can therefore be written during the current frame.
- `TxD_busy` timing: rises with the start-bit edge and falls at the end of the final stop bit when no byte follows.

## Structure
- Shared package `uart_pkg`, common with the receiver:
  - `OVERSAMPLE_DEF=16` and `DATA_BITS=8`.
  - The `uart_tx_state_t` enum: IDLE, START, DATA, STOP.
- A single flat module. No sub-module is warranted, because the tick counter, shifter and holding register are each only a few lines.

## Test plan
- 0xA5, `Baud16Tick` every 4 clocks, `CTS_in=1` → line 0,1,0,1,0,0,1,0,1,1, each 16 ticks (64 clocks). `TxD_ready` low for exactly one cycle window until the start edge.
- Back-to-back 0x55 then 0x0F, with the second byte written during the first frame → 320 contiguous ticks, no idle gap. The stop bit of frame 1 is followed by the start bit of frame 2. `TxD_busy` stays high throughout.
- `CTS_in=0`, write 0x3C → line stays 1 and `TxD_ready=0`. A second write of 0xFF is ignored. Raising `CTS_in` → 0x3C is sent, not 0xFF.
- `CTS_in` dropped at data bit 3 of 0x81 → full frame completes. The next queued byte is held until `CTS_in` returns.
- `sys_rst_n` pulsed low at data bit 5 → `TxD_ser=1` asynchronously, `TxD_ready=1`, `TxD_busy=0`. The next write of 0x12 produces a clean full frame.
- `STOP_BITS=2`, 0x00 → start plus 8 zero bits, then 32 high ticks before the next start. Frame is 176 ticks.
